// File: rtl/noc_packet_checker_if.sv
// noc_packet_checker_if: valid/ready flit handshake on the router ejection port
`ifndef Noc_Data_Width
`define Noc_Data_Width 32
`endif
`ifndef Noc_ID_X_Width
`define Noc_ID_X_Width 2
`endif
`ifndef Noc_ID_Y_Width
`define Noc_ID_Y_Width 2
`endif
`ifndef Noc_Point_H
`define Noc_Point_H 32
`endif
`ifndef Noc_Source_Point
`define Noc_Source_Point 28
`endif

interface noc_packet_checker_if;
    logic                       receive_valid;
    logic                       receive_ready;
    logic [`Noc_Data_Width-1:0] receive_flit;
    logic                       receive_is_header;
    logic                       receive_is_tail;
    modport master (output receive_valid, receive_flit, receive_is_header, receive_is_tail, input receive_ready);
    modport slave (input receive_valid, receive_flit, receive_is_header, receive_is_tail, output receive_ready);
endinterface

// File: rtl/noc_packet_checker.sv
// noc_packet_checker: ejection-port packet checker; NOC_CHK_TIMEOUT_EN adds an in-packet idle timeout
`ifndef Noc_Data_Width
`define Noc_Data_Width 32
`endif
`ifndef Noc_ID_X_Width
`define Noc_ID_X_Width 2
`endif
`ifndef Noc_ID_Y_Width
`define Noc_ID_Y_Width 2
`endif
`ifndef Noc_Point_H
`define Noc_Point_H 32
`endif
`ifndef Noc_Source_Point
`define Noc_Source_Point 28
`endif

module noc_packet_checker #(
    parameter logic [`Noc_ID_X_Width-1:0] X_ID           = '0,
    parameter logic [`Noc_ID_Y_Width-1:0] Y_ID           = '0,
    parameter int unsigned                EXP_DATA_FLITS = 11,
    parameter logic [`Noc_Data_Width-1:0] DATA_PATTERN   = '1,
    parameter int unsigned                TIMEOUT_CYCLES = 64
) (
    input  logic                       noc_clk,
    input  logic                       noc_rst,
    noc_packet_checker_if.slave        rx,
    input  logic                       stall,
    output logic                       pkt_done,
    output logic                       pkt_ok,
    output logic [3:0]                 pkt_err_code,
    output logic [`Noc_ID_X_Width-1:0] pkt_src_x,
    output logic [`Noc_ID_Y_Width-1:0] pkt_src_y,
    output logic [7:0]                 pkt_len,
    output logic [15:0]                good_count,
    output logic [15:0]                err_count
);
    localparam int YW = `Noc_ID_Y_Width;
    localparam int IW = `Noc_ID_X_Width + `Noc_ID_Y_Width;

    typedef enum logic {IDLE, DATA} state_t;

    state_t        state_q, state_d;
    logic          ready_q, ready_d;
    logic [IW-1:0] src_q, src_d, dst_q, dst_d;
    logic [3:0]    code_q, code_d;
    logic [7:0]    cnt_q, cnt_d;
    logic          done_q, done_d, ok_q, ok_d;
    logic [3:0]    res_code_q, res_code_d;
    logic [IW-1:0] res_src_q, res_src_d;
    logic [7:0]    len_q, len_d;
    logic [15:0]   good_q, good_d, err_q, err_d;
    logic          xfer, close, timeout;
    logic [3:0]    close_code;
    logic [IW-1:0] close_src;
    logic [7:0]    close_len;
    logic [IW-1:0] f_src, f_dst;

    assign f_src = rx.receive_flit[`Noc_Point_H-1:`Noc_Source_Point];
    assign f_dst = rx.receive_flit[`Noc_Source_Point-1 -: IW];
    assign xfer  = rx.receive_valid & ready_q;

`ifdef NOC_CHK_TIMEOUT_EN
    logic [15:0] idle_q, idle_d;
    assign idle_d  = (state_q == DATA && !xfer) ? idle_q + 16'd1 : 16'd0;
    assign timeout = state_q == DATA && !xfer && idle_q == 16'(TIMEOUT_CYCLES - 1);
    // Idle cycles spent inside a packet; any transfer or packet start clears it
    always_ff @(posedge noc_clk) begin
        idle_q <= noc_rst ? 16'd0 : idle_d;
    end
`else
    localparam int unsigned unused_timeout = TIMEOUT_CYCLES;
    assign timeout = 1'b0;
`endif

    // Packet framing FSM: tracks the open packet and decides when a result closes
    always_comb begin
        state_d    = state_q;
        src_d      = src_q;
        dst_d      = dst_q;
        code_d     = code_q;
        cnt_d      = cnt_q;
        close      = 1'b0;
        close_code = code_q;
        close_src  = src_q;
        close_len  = cnt_q;
        if (state_q == IDLE) begin
            if (xfer && rx.receive_is_header && rx.receive_is_tail) begin
                close      = 1'b1;
                close_code = 4'd7;
                close_src  = f_src;
                close_len  = 8'd0;
            end else if (xfer && rx.receive_is_header) begin
                state_d = DATA;
                src_d   = f_src;
                dst_d   = f_dst;
                cnt_d   = 8'd0;
                code_d  = (f_dst != {X_ID, Y_ID}) ? 4'd1 : 4'd0;
            end else if (xfer) begin
                close      = 1'b1;
                close_code = 4'd6;
                close_src  = '0;
                close_len  = 8'd0;
            end
        end else if (xfer && rx.receive_is_header) begin
            close      = 1'b1;
            close_code = (code_q != 4'd0) ? code_q : 4'd5;
            src_d      = f_src;
            dst_d      = f_dst;
            cnt_d      = 8'd0;
            code_d     = (f_dst != {X_ID, Y_ID}) ? 4'd1 : 4'd0;
        end else if (xfer && rx.receive_is_tail) begin
            close      = 1'b1;
            state_d    = IDLE;
            close_code = (code_q != 4'd0) ? code_q :
                         (cnt_q != 8'(EXP_DATA_FLITS)) ? 4'd2 :
                         (f_src != src_q || f_dst != dst_q) ? 4'd4 : 4'd0;
        end else if (xfer) begin
            cnt_d  = (cnt_q == 8'hFF) ? cnt_q : cnt_q + 8'd1;
            code_d = (code_q == 4'd0 && rx.receive_flit != DATA_PATTERN) ? 4'd3 : code_q;
        end else if (timeout) begin
            close      = 1'b1;
            state_d    = IDLE;
            close_code = (code_q != 4'd0) ? code_q : 4'd8;
        end
    end

    // Result capture, saturating counters and registered ready
    always_comb begin
        ready_d    = ~stall;
        done_d     = close;
        ok_d       = close ? (close_code == 4'd0) : ok_q;
        res_code_d = close ? close_code : res_code_q;
        res_src_d  = close ? close_src : res_src_q;
        len_d      = close ? close_len : len_q;
        good_d     = (close && close_code == 4'd0 && good_q != 16'hFFFF) ? good_q + 16'd1 : good_q;
        err_d      = (close && close_code != 4'd0 && err_q != 16'hFFFF) ? err_q + 16'd1 : err_q;
    end

    // State and result registers
    always_ff @(posedge noc_clk) begin
        if (noc_rst) begin
            state_q    <= IDLE;
            ready_q    <= 1'b0;
            src_q      <= '0;
            dst_q      <= '0;
            code_q     <= 4'd0;
            cnt_q      <= 8'd0;
            done_q     <= 1'b0;
            ok_q       <= 1'b0;
            res_code_q <= 4'd0;
            res_src_q  <= '0;
            len_q      <= 8'd0;
            good_q     <= 16'd0;
            err_q      <= 16'd0;
        end else begin
            state_q    <= state_d;
            ready_q    <= ready_d;
            src_q      <= src_d;
            dst_q      <= dst_d;
            code_q     <= code_d;
            cnt_q      <= cnt_d;
            done_q     <= done_d;
            ok_q       <= ok_d;
            res_code_q <= res_code_d;
            res_src_q  <= res_src_d;
            len_q      <= len_d;
            good_q     <= good_d;
            err_q      <= err_d;
        end
    end

    assign rx.receive_ready = ready_q;
    assign pkt_done         = done_q;
    assign pkt_ok           = ok_q;
    assign pkt_err_code     = res_code_q;
    assign pkt_src_x        = res_src_q[IW-1:YW];
    assign pkt_src_y        = res_src_q[YW-1:0];
    assign pkt_len          = len_q;
    assign good_count       = good_q;
    assign err_count        = err_q;
endmodule

// File: doc/noc_packet_checker.md
Name: noc_packet_checker

Overview:
- Receive-side consumer attached to a router ejection (local) port, in place of a traffic node's receive logic.
- Accepts header/data/tail flits over the valid/ready flit interface and checks each packet for:
  - correct destination;
  - expected payload length and pattern;
  - consistent tail IDs;
  - correct framing.
- Reports a per-packet result pulse and saturating good/error counters for the NoC test bench.

Parameters:
- X_ID, 0, local node X coordinate (`Noc_ID_X_Width bits).
- Y_ID, 0, local node Y coordinate (`Noc_ID_Y_Width bits).
- EXP_DATA_FLITS, 11, required number of data flits between header and tail (1..255).
- DATA_PATTERN, all ones (`Noc_Data_Width bits), required value of every data flit.
- TIMEOUT_CYCLES, 64, idle-cycle limit inside a packet (used only with the optional feature).

Ports:
- noc_clk  in  1  clock.
- noc_rst  in  1  synchronous, active-high reset.
- receive_valid  in  1  flit valid from router.
- receive_ready  out  1  checker can accept a flit.
- receive_flit  in  `Noc_Data_Width  flit payload.
- receive_is_header  in  1  flit is a header.
- receive_is_tail  in  1  flit is a tail.
- stall  in  1  bench-driven backpressure request.
- pkt_done  out  1  one-cycle result pulse.
- pkt_ok  out  1  packet passed all checks (valid with pkt_done).
- pkt_err_code  out  4  first error detected in the packet, 0 = none.
- pkt_src_x  out  `Noc_ID_X_Width  source X from the header.
- pkt_src_y  out  `Noc_ID_Y_Width  source Y from the header.
- pkt_len  out  8  data flits counted.
- good_count  out  16  packets with pkt_ok = 1, saturating.
- err_count  out  16  results with pkt_ok = 0, saturating.

Behaviour:
- Clock and reset:
  - One clock, noc_clk. Reset noc_rst is synchronous and active-high.
  - Reset values: all outputs 0, including receive_ready. State returns to IDLE; captured fields and counters clear.
  - Reset asserted mid-packet discards the packet with no pulse.
- Ready and transfer:
  - receive_ready is registered: receive_ready <= ~stall. It follows stall with 1-cycle latency and rises on the first cycle after reset release if stall = 0.
  - Transfer = receive_valid & receive_ready. Only transfers are inspected.
- Field positions:
  - Source ID = flit[`Noc_Point_H-1 : `Noc_Source_Point]; X is the upper `Noc_ID_X_Width bits, Y the lower bits.
  - Destination ID = the (`Noc_ID_X_Width + `Noc_ID_Y_Width) bits directly below the source field, split the same way.
- Error codes: 1 destination mismatch; 2 length; 3 payload mismatch; 4 tail source/destination differs from header; 5 header inside packet; 6 orphan data/tail flit; 7 header and tail on the same flit; 8 timeout.
  - The first error in a packet is sticky.
  - If several errors arise on the same flit, the lowest code wins.
- States:
  - IDLE:
    - Header transfer: capture source, clear data count, set code 1 if destination differs from (X_ID, Y_ID), go to DATA.
    - Header with is_tail = 1: emit result code 7, stay IDLE.
    - Non-header transfer: emit result code 6 with source 0 and length 0, stay IDLE.
  - DATA:
    - Data transfer: count++, saturating at 255. Set code 3 if flit != DATA_PATTERN.
    - Tail transfer: set code 2 if count != EXP_DATA_FLITS; set code 4 if the tail source or destination differs from the header's. Emit result, go to IDLE.
    - Header transfer: emit result for the open packet with code 5, then start a new packet from this header (stay DATA). The new packet does not inherit any error.
- Result:
  - pkt_done pulses in the cycle after the closing transfer, with pkt_ok = (code == 0) and the other fields held until the next pulse.
  - Exactly one of good_count / err_count increments per pulse; both saturate at 16'hFFFF.
- Latency: flit acceptance at 1 flit/cycle sustained; result 1 cycle after the tail.

Optional Feature:
- NOC_CHK_TIMEOUT_EN defined:
  - A 16-bit idle counter runs in DATA, clears on any transfer, and clears on entry to DATA.
  - When it reaches TIMEOUT_CYCLES, the checker emits a result with code 8 (len = count so far) and returns to IDLE.
  - A later tail is then reported as orphan (code 6).
- Not defined: no counter; the checker waits in DATA indefinitely; code 8 never occurs.

Test Plan:
- Header from (1,0) to (X_ID,Y_ID), 11 all-ones data flits, tail, stall = 0 -> pkt_done one cycle after tail, pkt_ok = 1, code 0, src (1,0), len 11, good_count = 1.
- Same packet with destination (2,2) != local and data flit 5 = 0 -> pkt_ok = 0, code 1 (first error sticky), err_count = 1.
- Packet with 9 data flits -> code 2, len 9. Then a tail with no header -> second pulse, code 6, err_count = 2.
- Header, 3 data flits, second header, 11 data flits, tail -> pulse code 5 (len 3), then pulse code 0 (len 11).
- Toggle stall every 3 cycles during a valid packet -> no transfer while receive_ready = 0; result identical to the no-stall case. Assert noc_rst mid-packet -> all outputs 0, no pulse.
- With NOC_CHK_TIMEOUT_EN, TIMEOUT_CYCLES = 8: header, 2 data flits, valid low 8 cycles -> pulse code 8, len 2. Late tail -> code 6.
